// File: rtl/dist_pkg.sv
// Shared types and default widths for the disparity decision stage.
// Second-best tracking and out_lowconf exist only when PEAK_MARGIN_EN is defined.
package dist_pkg;

   localparam int RES_W_DEF   = 18;
   localparam int PLACE_W_DEF = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      HOLD = 2'd2
   } state_t;

endpackage

// File: rtl/best_place_picker_peak_tracker.sv
// Best/place (and optional second-best) registers plus the strict unsigned comparison.
// Second-best logic and the next-cycle low-confidence flag are built only with PEAK_MARGIN_EN.
module peak_tracker
   import dist_pkg::*;
#(
   parameter int RES_W   = RES_W_DEF,
   parameter int PLACE_W = PLACE_W_DEF,
   parameter int MARGIN  = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               sample,
   input  logic               load_first,
   input  logic [RES_W-1:0]   in_result,
   input  logic [PLACE_W-1:0] in_place,
`ifdef PEAK_MARGIN_EN
   output logic               nxt_lowconf,
`endif
   output logic [RES_W-1:0]   best,
   output logic [PLACE_W-1:0] place
);

   logic take_new;

   // The first candidate always wins, even if its result is zero; later ones need a strict win.
   assign take_new = sample && (load_first || (in_result > best));

`ifdef PEAK_MARGIN_EN
   logic [RES_W-1:0] second;
   logic [RES_W-1:0] nxt_best;
   logic [RES_W-1:0] nxt_second;

   // best never drops below second, so the subtraction cannot underflow.
   always_comb begin
      nxt_best   = best;
      nxt_second = second;
      if (take_new) begin
         nxt_best   = in_result;
         nxt_second = best;
      end else if (sample && (in_result > second)) begin
         nxt_second = in_result;
      end
      nxt_lowconf = (nxt_best - nxt_second) < RES_W'(MARGIN);
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         second <= '0;
      end else begin
         second <= nxt_second;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         best  <= '0;
         place <= '0;
      end else if (take_new) begin
         best  <= in_result;
         place <= in_place;
      end
   end

endmodule

// File: rtl/best_place_picker.sv
// Scan FSM, candidate counter and valid/ready output for the disparity winner.
// Define PEAK_MARGIN_EN to add second-best tracking and the out_lowconf port.
module best_place_picker
   import dist_pkg::*;
#(
   parameter int RES_W   = RES_W_DEF,
   parameter int PLACE_W = PLACE_W_DEF,
   parameter int NCAND   = 64,
   parameter int MARGIN  = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               scan_start,
   input  logic               in_valid,
   input  logic [RES_W-1:0]   in_result,
   input  logic [PLACE_W-1:0] in_place,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PLACE_W-1:0] out_place,
   output logic [RES_W-1:0]   out_result,
   output logic               busy,
   output logic               scan_abort,
`ifdef PEAK_MARGIN_EN
   output logic               out_lowconf,
`endif
   output logic               scan_drop
);

   localparam int CW = $clog2(NCAND + 1);

   state_t        state;
   logic [CW-1:0] count;
   logic          clear;
   logic          sample;
   logic          last_cand;

   // A start clears the tracker whenever the FSM will honour it; a dropped start must not.
   assign clear     = scan_start && ((state == IDLE) || (state == SCAN) ||
                                     ((state == HOLD) && out_ready));
   assign sample    = (state == SCAN) && in_valid && !scan_start;
   assign last_cand = (count == CW'(NCAND - 1));

`ifdef PEAK_MARGIN_EN
   logic nxt_lowconf;
`endif

   peak_tracker #(
      .RES_W   (RES_W),
      .PLACE_W (PLACE_W),
      .MARGIN  (MARGIN)
   ) u_tracker (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear       (clear),
      .sample      (sample),
      .load_first  (count == '0),
      .in_result   (in_result),
      .in_place    (in_place),
`ifdef PEAK_MARGIN_EN
      .nxt_lowconf (nxt_lowconf),
`endif
      .best        (out_result),
      .place       (out_place)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         count      <= '0;
         out_valid  <= 1'b0;
         busy       <= 1'b0;
         scan_abort <= 1'b0;
         scan_drop  <= 1'b0;
`ifdef PEAK_MARGIN_EN
         out_lowconf <= 1'b0;
`endif
      end else begin
         scan_abort <= 1'b0;
         scan_drop  <= 1'b0;
         case (state)
            IDLE: begin
               if (scan_start) begin
                  state <= SCAN;
                  count <= '0;
                  busy  <= 1'b1;
               end
            end
            SCAN: begin
               if (scan_start) begin
                  count      <= '0;
                  scan_abort <= 1'b1;
               end else if (in_valid) begin
                  if (last_cand) begin
                     state     <= HOLD;
                     count     <= CW'(NCAND);
                     out_valid <= 1'b1;
`ifdef PEAK_MARGIN_EN
                     out_lowconf <= nxt_lowconf;
`endif
                  end else begin
                     count <= count + 1'b1;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  count     <= '0;
`ifdef PEAK_MARGIN_EN
                  out_lowconf <= 1'b0;
`endif
                  if (scan_start) begin
                     state <= SCAN;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else if (scan_start) begin
                  scan_drop <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               count     <= '0;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_best_place_picker.sv
// Self-checking bench for best_place_picker with NCAND=4; winners come from a list-based model.
// Low-confidence checks are compiled in only when PEAK_MARGIN_EN is defined.
module tb_best_place_picker;

   localparam int RES_W   = 18;
   localparam int PLACE_W = 6;
   localparam int NCAND   = 4;
   localparam int MARGIN  = 16;

   logic               clk;
   logic               rst_n;
   logic               scan_start;
   logic               in_valid;
   logic [RES_W-1:0]   in_result;
   logic [PLACE_W-1:0] in_place;
   logic               out_valid;
   logic               out_ready;
   logic [PLACE_W-1:0] out_place;
   logic [RES_W-1:0]   out_result;
   logic               busy;
   logic               scan_abort;
   logic               scan_drop;
`ifdef PEAK_MARGIN_EN
   logic               out_lowconf;
`endif

   int errors = 0;
   int checks = 0;

   best_place_picker #(
      .RES_W   (RES_W),
      .PLACE_W (PLACE_W),
      .NCAND   (NCAND),
      .MARGIN  (MARGIN)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .scan_start  (scan_start),
      .in_valid    (in_valid),
      .in_result   (in_result),
      .in_place    (in_place),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_place   (out_place),
      .out_result  (out_result),
      .busy        (busy),
      .scan_abort  (scan_abort),
`ifdef PEAK_MARGIN_EN
      .out_lowconf (out_lowconf),
`endif
      .scan_drop   (scan_drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change and outputs are observed 1 ns after each rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic start_scan();
      scan_start = 1'b1;
      in_valid   = 1'b1;
      in_result  = 18'h3ffff;
      in_place   = 6'd63;
      cyc();
      scan_start = 1'b0;
      in_valid   = 1'b0;
   endtask

   task automatic feed(input int r, input int p);
      in_valid  = 1'b1;
      in_result = RES_W'(r);
      in_place  = PLACE_W'(p);
      cyc();
      in_valid  = 1'b0;
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      cyc();
      cyc();
      rst_n = 1'b1;
      checks++;
      if ({out_valid, busy, scan_abort, scan_drop} !== 4'b0 || out_place !== '0 || out_result !== '0) begin
         errors++;
         $display("[TB] FAIL reset: valid=%b busy=%b abort=%b drop=%b place=%0d result=%0d, required all 0",
                  out_valid, busy, scan_abort, scan_drop, out_place, out_result);
      end
   endtask

   task automatic test_basic();
      start_scan();
      feed(10, 0);
      feed(30, 1);
      feed(20, 2);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL basic_early: valid=%b busy=%b, required 0/1", out_valid, busy);
      end
      feed(5, 3);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_place !== 6'd1 || out_result !== 18'd30) begin
            errors++;
            $display("[TB] FAIL basic_hold%0d: valid=%b place=%0d result=%0d, required 1/1/30",
                     i, out_valid, out_place, out_result);
         end
         cyc();
      end
      handshake();
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL basic_done: valid=%b busy=%b, required 0/0", out_valid, busy);
      end
   endtask

   task automatic test_tie();
      start_scan();
      feed(7, 0);
      feed(9, 1);
      feed(9, 2);
      feed(3, 3);
      checks++;
      if (out_valid !== 1'b1 || out_place !== 6'd1 || out_result !== 18'd9) begin
         errors++;
         $display("[TB] FAIL tie: valid=%b place=%0d result=%0d, required 1/1/9",
                  out_valid, out_place, out_result);
      end
      handshake();
   endtask

   task automatic test_restart();
      start_scan();
      feed(100, 0);
      feed(150, 1);
      scan_start = 1'b1;
      in_valid   = 1'b1;
      in_result  = 18'd500;
      in_place   = 6'd9;
      cyc();
      scan_start = 1'b0;
      in_valid   = 1'b0;
      checks++;
      if (scan_abort !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL restart_abort: abort=%b busy=%b valid=%b, required 1/1/0",
                  scan_abort, busy, out_valid);
      end
      feed(1, 0);
      checks++;
      if (scan_abort !== 1'b0) begin
         errors++;
         $display("[TB] FAIL restart_pulse: abort=%b, required 0", scan_abort);
      end
      feed(2, 1);
      feed(3, 2);
      feed(4, 3);
      checks++;
      if (out_valid !== 1'b1 || out_place !== 6'd3 || out_result !== 18'd4) begin
         errors++;
         $display("[TB] FAIL restart_win: valid=%b place=%0d result=%0d, required 1/3/4",
                  out_valid, out_place, out_result);
      end
      handshake();
   endtask

   task automatic test_hold_drop();
      start_scan();
      feed(10, 0);
      feed(40, 1);
      feed(20, 2);
      feed(30, 3);
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         scan_start = (i == 2);
         cyc();
         scan_start = 1'b0;
         checks++;
         if (out_valid !== 1'b1 || out_place !== 6'd1 || out_result !== 18'd40 ||
             scan_drop !== (i == 2)) begin
            errors++;
            $display("[TB] FAIL hold_drop%0d: valid=%b place=%0d result=%0d drop=%b, required 1/1/40/%0d",
                     i, out_valid, out_place, out_result, scan_drop, (i == 2));
         end
      end
      out_ready  = 1'b1;
      scan_start = 1'b1;
      cyc();
      out_ready  = 1'b0;
      scan_start = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b1 || scan_drop !== 1'b0) begin
         errors++;
         $display("[TB] FAIL hold_restart: valid=%b busy=%b drop=%b, required 0/1/0",
                  out_valid, busy, scan_drop);
      end
      feed(5, 10);
      feed(6, 11);
      feed(50, 12);
      feed(7, 13);
      checks++;
      if (out_valid !== 1'b1 || out_place !== 6'd12 || out_result !== 18'd50) begin
         errors++;
         $display("[TB] FAIL hold_next: valid=%b place=%0d result=%0d, required 1/12/50",
                  out_valid, out_place, out_result);
      end
      handshake();
   endtask

   task automatic test_reset_mid();
      start_scan();
      feed(70, 4);
      feed(80, 5);
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      checks++;
      if ({out_valid, busy} !== 2'b0 || out_place !== '0 || out_result !== '0) begin
         errors++;
         $display("[TB] FAIL reset_mid: valid=%b busy=%b place=%0d result=%0d, required all 0",
                  out_valid, busy, out_place, out_result);
      end
      for (int i = 0; i < 6; i++) feed(900 + i, i);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL idle_ignore: valid=%b busy=%b, required 0/0", out_valid, busy);
      end
   endtask

   // Winner is the earliest maximum; second is the largest of the remaining candidates.
   task automatic test_random();
      int  r[NCAND];
      int  p[NCAND];
      int  bi;
      int  sec;
      bit  started = 1'b0;
      bit  chain;
      for (int s = 0; s < 25; s++) begin
         if (!started) start_scan();
         for (int i = 0; i < NCAND; i++) begin
            r[i] = (s % 2 == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 262143));
            p[i] = int'($urandom_range(0, 63));
         end
         bi = 0;
         for (int i = 1; i < NCAND; i++) if (r[i] > r[bi]) bi = i;
         sec = 0;
         for (int i = 0; i < NCAND; i++) if (i != bi && r[i] > sec) sec = r[i];
         for (int i = 0; i < NCAND; i++) begin
            while ($urandom_range(0, 3) == 0) cyc();
            feed(r[i], p[i]);
         end
         checks++;
         if (out_valid !== 1'b1 || out_place !== PLACE_W'(p[bi]) || out_result !== RES_W'(r[bi])) begin
            errors++;
            $display("[TB] FAIL random%0d: valid=%b place=%0d result=%0d, required 1/%0d/%0d",
                     s, out_valid, out_place, out_result, p[bi], r[bi]);
         end
`ifdef PEAK_MARGIN_EN
         checks++;
         if (out_lowconf !== ((r[bi] - sec) < MARGIN)) begin
            errors++;
            $display("[TB] FAIL random_lowconf%0d: got %b, required %0d", s, out_lowconf,
                     ((r[bi] - sec) < MARGIN));
         end
`endif
         repeat ($urandom_range(0, 2)) cyc();
         chain      = (s != 24) && ($urandom_range(0, 1) == 1);
         out_ready  = 1'b1;
         scan_start = chain;
         cyc();
         out_ready  = 1'b0;
         scan_start = 1'b0;
         started    = chain;
         checks++;
         if (out_valid !== 1'b0 || busy !== chain) begin
            errors++;
            $display("[TB] FAIL random_back%0d: valid=%b busy=%b, required 0/%0d",
                     s, out_valid, busy, chain);
         end
      end
   endtask

`ifdef PEAK_MARGIN_EN
   task automatic test_lowconf();
      start_scan();
      feed(100, 0);
      feed(90, 1);
      feed(20, 2);
      feed(0, 3);
      checks++;
      if (out_lowconf !== 1'b1 || out_place !== 6'd0) begin
         errors++;
         $display("[TB] FAIL lowconf_close: lowconf=%b place=%0d, required 1/0", out_lowconf, out_place);
      end
      handshake();
      start_scan();
      feed(100, 0);
      feed(80, 1);
      feed(20, 2);
      feed(0, 3);
      checks++;
      if (out_lowconf !== 1'b0) begin
         errors++;
         $display("[TB] FAIL lowconf_wide: lowconf=%b, required 0", out_lowconf);
      end
      handshake();
   endtask
`endif

   initial begin
      rst_n      = 1'b0;
      scan_start = 1'b0;
      in_valid   = 1'b0;
      in_result  = '0;
      in_place   = '0;
      out_ready  = 1'b0;
      test_reset();
      test_basic();
      test_tie();
      test_restart();
      test_hold_drop();
      test_reset_mid();
`ifdef PEAK_MARGIN_EN
      test_lowconf();
`endif
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
